// File: rtl/adrv9001_rx_capture_pkg.sv
// Shared types and constants for the ADRV9001 receive capture block.
// Optional feature macro used by the block: ADRV9001_RX_CAPTURE_TSTAMP_EN.
package adrv9001_rx_capture_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCapture
  } state_e;

  localparam int unsigned TSTAMP_W   = 32;
  localparam int unsigned DROP_CNT_W = 16;

  // Saturating increment for the dropped-sample counter.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/adrv9001_rx_capture_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset (discards contents)
//   wr_en_i/wr_data_i write request and data
//   wr_ready_o        write will be accepted this cycle (not full, or a read frees a slot)
//   rd_en_i           consumer ready; a read happens when rd_en_i and not empty
//   rd_data_o         head entry, zero while empty
//   empty_o           no entries
//   level_o           occupancy, updates the cycle after each write/read
module adrv9001_rx_capture_fifo #(
  parameter int unsigned Width     = 33,
  parameter int unsigned AddrWidth = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en_i,
  input  logic [Width-1:0]     wr_data_i,
  output logic                 wr_ready_o,
  input  logic                 rd_en_i,
  output logic [Width-1:0]     rd_data_o,
  output logic                 empty_o,
  output logic [AddrWidth:0]   level_o
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [AddrWidth:0] wr_ptr_q, rd_ptr_q;
  logic [Width-1:0]   mem_q [Depth];
  logic               full, rd_fire, wr_fire;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AddrWidth] != rd_ptr_q[AddrWidth]) &&
                      (wr_ptr_q[AddrWidth-1:0] == rd_ptr_q[AddrWidth-1:0]);
  assign rd_fire    = rd_en_i & ~empty_o;
  assign wr_ready_o = ~full | rd_fire;
  assign wr_fire    = wr_en_i & wr_ready_o;
  assign level_o    = wr_ptr_q - rd_ptr_q;
  assign rd_data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AddrWidth-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q[AddrWidth-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/adrv9001_rx_capture.sv
// Frames the no-backpressure ADRV9001 receive IQ stream into frame_len-sample AXI-stream
// packets with tlast, buffers them in a FWFT FIFO and counts samples dropped on overflow.
// Optional: define ADRV9001_RX_CAPTURE_TSTAMP_EN to carry a per-frame timestamp on tuser.
// Ports:
//   s_axis_aclk/rstn   clock, asynchronous active-low reset
//   s_axis_tdata/valid input samples (cannot be stalled)
//   arm, trig          capture start control; continuous selects back-to-back frames
//   frame_len          samples per frame, latched on arm rising edge (0 ignores arm)
//   m_axis_*           buffered AXI-stream output (tuser = frame timestamp or 0)
//   busy, overflow, drop_cnt, fifo_level   status
module adrv9001_rx_capture
  import adrv9001_rx_capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_rstn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  arm,
  input  logic                  trig,
  input  logic                  continuous,
  input  logic [15:0]           frame_len,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           m_axis_tuser,
  output logic                  busy,
  output logic                  overflow,
  output logic [15:0]           drop_cnt,
  output logic [ADDR_WIDTH:0]   fifo_level
);

`ifdef ADRV9001_RX_CAPTURE_TSTAMP_EN
  localparam int unsigned FifoW = DATA_WIDTH + 1 + TSTAMP_W;
`else
  localparam int unsigned FifoW = DATA_WIDTH + 1;
`endif

  state_e                state_q, state_d;
  logic                  arm_q;
  logic [15:0]           len_q, len_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic             arm_rise, sample_ok, wr_en, wr_last, wr_ready, fifo_empty;
  logic [FifoW-1:0] fifo_wdata, fifo_rdata;

  assign arm_rise = arm & ~arm_q;
  // The trigger sample in ARMED is handled like any capture sample (it is sample 0).
  assign sample_ok = s_axis_tvalid &
                     ((state_q == StCapture) || ((state_q == StArmed) && trig));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    wr_en   = 1'b0;
    wr_last = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arm_rise && (frame_len != '0)) begin
          state_d = StArmed;
          len_d   = frame_len;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          drop_d  = '0;
        end
      end
      StArmed: begin
        if (s_axis_tvalid && trig) state_d = StCapture;
        else if (!arm)             state_d = StIdle;
      end
      StCapture: ;
      default: state_d = StIdle;
    endcase

    if (sample_ok) begin
      if (wr_ready) begin
        wr_en   = 1'b1;
        wr_last = (cnt_q == len_q - 16'd1);
        if (wr_last) begin
          cnt_d = '0;
          if (!continuous || !arm) state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end else begin
        // Dropped: frame position is not advanced.
        ovf_d  = 1'b1;
        drop_d = sat_inc(drop_q);
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_rstn) begin
    if (!s_axis_rstn) begin
      state_q <= StIdle;
      arm_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

`ifdef ADRV9001_RX_CAPTURE_TSTAMP_EN
  logic [TSTAMP_W-1:0] ts_q, frame_ts_q, wr_tuser;

  // Sample 0 carries the live count; later samples reuse the stored frame value.
  assign wr_tuser   = (cnt_q == '0) ? ts_q : frame_ts_q;
  assign fifo_wdata = {wr_tuser, wr_last, s_axis_tdata};

  always_ff @(posedge s_axis_aclk or negedge s_axis_rstn) begin
    if (!s_axis_rstn) begin
      ts_q       <= '0;
      frame_ts_q <= '0;
    end else begin
      if (s_axis_tvalid)             ts_q       <= ts_q + 1'b1;
      if (wr_en && (cnt_q == '0))    frame_ts_q <= ts_q;
    end
  end

  assign m_axis_tuser = fifo_rdata[FifoW-1 -: TSTAMP_W];
`else
  assign fifo_wdata   = {wr_last, s_axis_tdata};
  assign m_axis_tuser = '0;
`endif

  adrv9001_rx_capture_fifo #(
    .Width     (FifoW),
    .AddrWidth (ADDR_WIDTH)
  ) u_fifo (
    .clk_i      (s_axis_aclk),
    .rst_ni     (s_axis_rstn),
    .wr_en_i    (wr_en),
    .wr_data_i  (fifo_wdata),
    .wr_ready_o (wr_ready),
    .rd_en_i    (m_axis_tready),
    .rd_data_o  (fifo_rdata),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  assign m_axis_tdata  = fifo_rdata[DATA_WIDTH-1:0];
  assign m_axis_tlast  = fifo_rdata[DATA_WIDTH];
  assign m_axis_tvalid = ~fifo_empty;
  assign busy          = (state_q != StIdle) || !fifo_empty;
  assign overflow      = ovf_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_adrv9001_rx_capture.sv
// Self-checking bench for adrv9001_rx_capture (FIFO depth 4).
module tb_adrv9001_rx_capture;

`ifdef ADRV9001_RX_CAPTURE_TSTAMP_EN
  localparam bit TsEn = 1'b1;
`else
  localparam bit TsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        arm = 1'b0, trig = 1'b1, cont = 1'b0;
  logic [15:0] frame_len = 16'd4;
  logic [31:0] m_tdata, m_tuser;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;
  logic        busy, overflow;
  logic [15:0] drop_cnt;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adrv9001_rx_capture #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (2)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_rstn   (rstn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .arm           (arm),
    .trig          (trig),
    .continuous    (cont),
    .frame_len     (frame_len),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .busy          (busy),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt),
    .fifo_level    (fifo_level)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [31:0] u;
  } beat_t;
  beat_t got[$];

  // Inputs only change at posedge+1, so negedge values are those seen at the next edge.
  always @(negedge clk) begin
    if (rstn && m_tvalid && m_tready) got.push_back('{d: m_tdata, l: m_tlast, u: m_tuser});
  end

  typedef struct {
    logic        arm, trig, cont, valid;
    logic [31:0] data;
    logic        ready;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_last, e_busy;
    logic [2:0]  e_level;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic a, t, c, v, input logic [31:0] d, input logic r,
                     input logic ev, input logic [31:0] ed, input logic el, eb,
                     input logic [2:0] elev);
    tbl.push_back('{arm: a, trig: t, cont: c, valid: v, data: d, ready: r, e_valid: ev,
                    e_data: ed, e_last: el, e_busy: eb, e_level: elev});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input string name, input logic [31:0] d, input logic l,
                             input logic [31:0] u, input bit cu);
    beat_t b;
    checks++;
    if (got.size() == 0) begin
      errors++;
      $display("FAIL %s: no beat, expected data %0h last %0b", name, d, l);
    end else begin
      b = got.pop_front();
      if (b.d !== d || b.l !== l || (cu && b.u !== u)) begin
        errors++;
        $display("FAIL %s: got d=%0h l=%0b u=%0h expected d=%0h l=%0b u=%0h",
                 name, b.d, b.l, b.u, d, l, u);
      end
    end
  endtask

  task automatic cyc(input logic a, input logic v, input logic [31:0] d);
    arm = a;
    s_tvalid = v;
    s_tdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst tvalid", m_tvalid, 0);
    chk("rst tdata", m_tdata, 0);
    chk("rst tlast", m_tlast, 0);
    chk("rst tuser", m_tuser, 0);
    chk("rst busy", busy, 0);
    chk("rst overflow", overflow, 0);
    chk("rst drop_cnt", drop_cnt, 0);
    chk("rst level", fifo_level, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single frame, len 4: beats 1..4, tlast on 4, samples 5..10 ignored
    add(1, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 1,  0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 2, 1,  1, 1, 0, 1, 1);
    add(0, 1, 0, 1, 3, 1,  1, 2, 0, 1, 1);
    add(0, 1, 0, 1, 4, 1,  1, 3, 0, 1, 1);
    add(0, 1, 0, 1, 5, 1,  1, 4, 1, 1, 1);
    for (int i = 6; i <= 10; i++) add(0, 1, 0, 1, i, 1,  0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    // Trigger qualifier: trig low for samples 1..6, first beat is 7
    add(1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) add(1, 0, 0, 1, i, 1,  0, 0, 0, 1, 0);
    add(1, 1, 0, 1, 7, 1,  0, 0, 0, 1, 0);
    add(1, 1, 0, 1, 8, 1,  1, 7, 0, 1, 1);
    add(1, 1, 0, 1, 9, 1,  1, 8, 0, 1, 1);
    add(1, 1, 0, 1, 10, 1, 1, 9, 0, 1, 1);
    add(0, 1, 0, 0, 0, 1,  1, 10, 1, 1, 1);
    add(0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      arm = tbl[i].arm;
      trig = tbl[i].trig;
      cont = tbl[i].cont;
      s_tvalid = tbl[i].valid;
      s_tdata = tbl[i].data;
      m_tready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("vec%0d tvalid", i), m_tvalid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d tdata", i), m_tdata, tbl[i].e_data);
        chk($sformatf("vec%0d tlast", i), m_tlast, tbl[i].e_last);
      end
      chk($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d level", i), fifo_level, tbl[i].e_level);
      @(posedge clk);
      #1;
    end

    // Continuous, len 3, arm lowered after sample 5
    got.delete();
    frame_len = 16'd3;
    cont = 1'b1;
    trig = 1'b1;
    m_tready = 1'b1;
    cyc(1, 0, 0);
    for (int i = 1; i <= 5; i++) cyc(1, 1, i);
    for (int i = 6; i <= 9; i++) cyc(0, 1, i);
    repeat (3) cyc(0, 0, 0);
    for (int i = 1; i <= 6; i++)
      expect_beat($sformatf("cont beat%0d", i), i, (i % 3) == 0, 0, !TsEn);
    chk("cont extra beats", got.size(), 0);
    @(negedge clk);
    chk("cont busy end", busy, 0);
    @(posedge clk);
    #1;

    // Overflow with depth 4: 6 samples, tready low
    got.delete();
    frame_len = 16'd8;
    cont = 1'b0;
    m_tready = 1'b0;
    cyc(1, 0, 0);
    for (int i = 1; i <= 6; i++) cyc(1, 1, i);
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("ovf level", fifo_level, 4);
    chk("ovf flag", overflow, 1);
    chk("ovf drop_cnt", drop_cnt, 2);
    chk("ovf head", m_tdata, 1);
    chk("ovf hold tvalid", m_tvalid, 1);
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    // Write while full with a simultaneous read must be accepted
    for (int i = 7; i <= 10; i++) cyc(0, 1, i);
    repeat (6) cyc(0, 0, 0);
    for (int i = 1; i <= 4; i++) expect_beat($sformatf("ovf beat%0d", i), i, 0, 0, !TsEn);
    for (int i = 7; i <= 10; i++) expect_beat($sformatf("ovf beat%0d", i), i, i == 10, 0, !TsEn);
    chk("ovf extra beats", got.size(), 0);
    chk("ovf drop_cnt after", drop_cnt, 2);

    // frame_len 0: arm ignored
    frame_len = 16'd0;
    arm = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("len0 busy", busy, 0);
    @(posedge clk);
    #1;
    cyc(0, 0, 0);

    // Arm edge clears overflow/drop_cnt; then reset mid-frame with 3 buffered
    frame_len = 16'd8;
    m_tready = 1'b0;
    cyc(1, 0, 0);
    @(negedge clk);
    chk("rearm overflow", overflow, 0);
    chk("rearm drop_cnt", drop_cnt, 0);
    chk("rearm busy", busy, 1);
    @(posedge clk);
    #1;
    for (int i = 11; i <= 13; i++) cyc(1, 1, i);
    @(negedge clk);
    chk("pre-rst level", fifo_level, 3);
    #1;
    arm = 1'b0;
    s_tvalid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mid-rst tvalid", m_tvalid, 0);
    chk("mid-rst level", fifo_level, 0);
    chk("mid-rst busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Re-arm after reset: continuous len 2, valid every cycle, timestamps 0,0,2,2,4,4
    got.delete();
    frame_len = 16'd2;
    cont = 1'b1;
    m_tready = 1'b1;
    cyc(1, 0, 0);
    for (int i = 21; i <= 24; i++) cyc(1, 1, i);
    for (int i = 25; i <= 27; i++) cyc(0, 1, i);
    repeat (4) cyc(0, 0, 0);
    for (int i = 0; i < 6; i++)
      expect_beat($sformatf("ts beat%0d", i), 21 + i, (i % 2) == 1,
                  TsEn ? 32'((i / 2) * 2) : 32'd0, 1'b1);
    chk("ts extra beats", got.size(), 0);
    @(negedge clk);
    chk("ts busy end", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
